// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO buffering result words ahead of the SPI transmitter.
// Optional saturating drop counter enabled by defining SPI_TX_FIFO_DROP_CNT_EN.
module spi_tx_fifo #(
    parameter int WIDTH       = 9,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                     sclk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_ready,
    input  logic                     fifo_read_enable,
    input  logic                     clear_flags,
    output logic [WIDTH-1:0]         data_out,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
`ifdef SPI_TX_FIFO_DROP_CNT_EN
    output logic [15:0]              drop_count,
`endif
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             rd_acc;
    logic             wr_acc;
    logic             drop;
    logic             rd_err;

    // A write into a full FIFO is still accepted when a read frees a slot this cycle.
    always_comb begin
        rd_acc = fifo_read_enable && !fifo_empty;
        wr_acc = data_ready && (!fifo_full || rd_acc);
        drop   = data_ready && fifo_full && !rd_acc;
        rd_err = fifo_read_enable && fifo_empty;
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            data_out    <= '0;
            fifo_empty  <= 1'b1;
            fifo_full   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            fifo_empty  <= (count_next == '0);
            fifo_full   <= (count_next == DEPTH_C);
            almost_full <= (count_next >= AFULL_C);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (rd_err) begin
                underflow <= 1'b1;
            end else if (clear_flags) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef SPI_TX_FIFO_DROP_CNT_EN
    // A drop coinciding with clear_flags restarts the count at one.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (clear_flags) begin
            drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/spi_tx_fifo.md
Name: spi_tx_fifo

Overview:
Synchronous 9-bit FIFO that buffers result words ahead of the SPI transmitter. Producers write with a single-cycle data_ready strobe. The SPI transmitter drains the FIFO with fifo_read_enable and samples data_out. The block provides empty/full/count status and a sticky overflow flag, so words lost during SPI backpressure are visible to the host.

Parameters:
WIDTH, 9, word width; matches the SPI frame payload.
DEPTH, 16, number of entries; must be a power of two and at least 2.
AFULL_LEVEL, 12, fill level at or above which almost_full asserts.

Ports:
sclk  input  1  system clock; all state updates on posedge.
reset_n  input  1  asynchronous active-low reset.
data_in  input  WIDTH  write data.
data_ready  input  1  write strobe; one word per cycle while high.
fifo_read_enable  input  1  read strobe from the SPI transmitter.
data_out  output  WIDTH  registered read data.
fifo_empty  output  1  high when count == 0.
fifo_full  output  1  high when count == DEPTH.
almost_full  output  1  high when count >= AFULL_LEVEL.
count  output  $clog2(DEPTH)+1  current fill level.
overflow  output  1  sticky; set when a write is dropped.
underflow  output  1  sticky; set when a read is attempted while empty.
clear_flags  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Clock and reset: one clock, sclk. reset_n is asynchronous and active-low.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, fifo_empty=1, fifo_full=0, almost_full=0, overflow=0, underflow=0. Storage array contents are not reset.
- Reset mid-operation: all in-flight words are discarded; the FIFO is empty on the first edge after reset_n deasserts.
- Pointers: $clog2(DEPTH) bits wide; wrap from DEPTH-1 to 0 by natural binary overflow.
- Write accepted when data_ready=1 and fifo_full=0:
  - mem[wr_ptr] <= data_in
  - wr_ptr increments
- Read accepted when fifo_read_enable=1 and fifo_empty=0:
  - data_out <= mem[rd_ptr]
  - rd_ptr increments
  - Latency: data_out is valid on the posedge after the edge that sampled fifo_read_enable, i.e. 1 cycle.
- data_out holds its last value when no read is accepted.
- Count update per cycle:
  - +1 on a write-only accept
  - -1 on a read-only accept
  - unchanged when both or neither are accepted
- Simultaneous read and write:
  - Full: both accepted; the read frees a slot in the same cycle, count stays DEPTH, no overflow.
  - Empty: the write is accepted, the read is rejected (no bypass), underflow sets, count becomes 1, data_out unchanged.
- Rejected write (data_ready=1 while fifo_full=1 and no same-cycle read): word dropped, overflow <= 1.
- Rejected read (fifo_read_enable=1 while empty): underflow <= 1, pointers unchanged.
- clear_flags=1: overflow and underflow clear next edge. A set event in the same cycle wins (flag stays 1).
- Status outputs (fifo_empty, fifo_full, almost_full) are registered, derived from the next count. They never lag count by a cycle.
- No FSM: the datapath is pointer/counter based. A fifo_read_enable held high drains one word per cycle until empty.

Optional Feature:
- Macro: SPI_TX_FIFO_DROP_CNT_EN.
- Defined: adds output drop_count [15:0].
  - Increments on every rejected write.
  - Saturates at 16'hFFFF.
  - Cleared by reset_n and by clear_flags.
  - A same-cycle drop together with clear_flags yields drop_count=1.
- Undefined: port and counter absent; only the sticky overflow flag reports drops.

Test Plan:
- Reset, then write 9'h152 and 9'h0A3 on consecutive cycles, then pulse fifo_read_enable twice -> data_out=9'h152, then 9'h0A3, one cycle after each read; count goes 0,1,2,1,0; fifo_empty=1 at the end.
- Write 16 words 0..15 with no reads -> fifo_full=1, count=16, almost_full rose when count reached 12. A 17th write of 9'h1FF -> overflow=1, count stays 16, and subsequent reads return 0..15 in order, never 9'h1FF.
- FIFO full, then assert data_ready and fifo_read_enable together for 20 cycles with an incrementing pattern -> count stays 16, no overflow; read data is the exact write sequence delayed by 16 words, including wrap-around of both pointers.
- FIFO empty, then assert write 9'h07E and read together -> underflow=1, count=1, data_out unchanged. The next read returns 9'h07E.
- Load 5 words, assert reset_n=0 asynchronously between edges -> outputs reach reset values immediately, without waiting for an edge. After release, fifo_empty=1 and a read sets underflow.
- With SPI_TX_FIFO_DROP_CNT_EN: fill the FIFO, then issue 3 extra writes -> drop_count=3. Pulse clear_flags -> drop_count=0 and overflow=0 next cycle.
